// File: rtl/bv_lookup_config_ctrl.sv
// Bit-vector lookup SRAM controller: arbitrates key lookups against
// config writes (with starvation bound) and runs a full zero-fill sweep.
//
// Ports:
//   clk, rst_n           clock, async active-low reset
//   lk_valid/lk_ready    lookup handshake; lk_din key, lk_mode upper addr
//   cfg_valid/cfg_ready  config write handshake; cfg_sel/addr/data
//   clear_start          request zero-fill of every SRAM word
//   sram_wr_en/rd_en     per-SRAM strobes (registered)
//   sram_addr/wdata      per-SRAM address/data slices (registered)
//   res_valid            read data valid, one cycle after rd_en
//   busy, clear_done     sweep in progress / end-of-sweep pulse
//   cfg_err              sticky out-of-range cfg_sel flag
module bv_lookup_config_ctrl #(
  parameter int SRAM_ADDR_WIDTH = 6,
  parameter int STRIDE          = 4,
  parameter int MODE_WIDTH      = 2,
  parameter int RESULT_WIDTH    = 64,
  parameter int SRAM_NUM        = 4,
  parameter int CFG_MAX_WAIT    = 8
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 lk_valid,
  output logic                                 lk_ready,
  input  logic [STRIDE*SRAM_NUM-1:0]           lk_din,
  input  logic [MODE_WIDTH-1:0]                lk_mode,
  input  logic                                 cfg_valid,
  output logic                                 cfg_ready,
  input  logic [7:0]                           cfg_sel,
  input  logic [SRAM_ADDR_WIDTH-1:0]           cfg_addr,
  input  logic [RESULT_WIDTH-1:0]              cfg_data,
  input  logic                                 clear_start,
  output logic [SRAM_NUM-1:0]                  sram_wr_en,
  output logic [SRAM_NUM-1:0]                  sram_rd_en,
  output logic [SRAM_ADDR_WIDTH*SRAM_NUM-1:0]  sram_addr,
  output logic [RESULT_WIDTH*SRAM_NUM-1:0]     sram_wdata,
  output logic                                 res_valid,
  output logic                                 busy,
  output logic                                 clear_done,
  output logic                                 cfg_err
);

  localparam int AW    = SRAM_ADDR_WIDTH;
  localparam int DEPTH = 1 << AW;
  localparam int CW    = AW + 1;

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t                     state_q, state_d;
  logic [7:0]                 wait_q, wait_d;
  logic [CW-1:0]              clr_q, clr_d;
  logic [SRAM_NUM-1:0]        wr_d, rd_d;
  logic [AW*SRAM_NUM-1:0]     addr_d;
  logic [RESULT_WIDTH*SRAM_NUM-1:0] wdata_d;
  logic                       done_d, err_d;
  logic                       idle, sat, lk_hs, cfg_hs, sel_ok;

  // Readies are forced low while reset is asserted.
  always_comb begin
    idle      = (state_q == IDLE);
    sat       = (wait_q == 8'(CFG_MAX_WAIT));
    lk_ready  = rst_n && idle && !clear_start
                && !(cfg_valid && sat);
    cfg_ready = rst_n && idle && !clear_start
                && (!lk_valid || sat);
    lk_hs     = lk_valid && lk_ready;
    cfg_hs    = cfg_valid && cfg_ready;
    sel_ok    = (cfg_sel < 8'(SRAM_NUM));
    busy      = (state_q == CLEAR);
  end

  always_comb begin
    state_d = state_q;
    clr_d   = clr_q;
    wait_d  = wait_q;
    wr_d    = '0;
    rd_d    = '0;
    addr_d  = sram_addr;
    wdata_d = sram_wdata;
    done_d  = 1'b0;
    err_d   = cfg_err;
    unique case (state_q)
      IDLE: begin
        if (clear_start) begin
          state_d = CLEAR;
          clr_d   = '0;
          err_d   = 1'b0;
        end else if (cfg_hs) begin
          if (!sel_ok) err_d = 1'b1;
          for (int i = 0; i < SRAM_NUM; i++) begin
            if (cfg_sel == 8'(i)) begin
              wr_d[i] = 1'b1;
              addr_d[AW*i +: AW] = cfg_addr;
              wdata_d[RESULT_WIDTH*i +: RESULT_WIDTH] = cfg_data;
            end
          end
        end else if (lk_hs) begin
          rd_d = '1;
          for (int i = 0; i < SRAM_NUM; i++)
            addr_d[AW*i +: AW] = {lk_mode, lk_din[STRIDE*i +: STRIDE]};
        end
      end
      CLEAR: begin
        // One extra CLEAR cycle after the last write issues clear_done.
        if (clr_q == CW'(DEPTH)) begin
          state_d = IDLE;
          clr_d   = '0;
          done_d  = 1'b1;
        end else begin
          wr_d    = '1;
          wdata_d = '0;
          clr_d   = clr_q + 1'b1;
          for (int i = 0; i < SRAM_NUM; i++)
            addr_d[AW*i +: AW] = clr_q[AW-1:0];
        end
      end
      default: state_d = IDLE;
    endcase
    if (!cfg_valid || cfg_hs) wait_d = '0;
    else if (idle && !sat) wait_d = wait_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      wait_q     <= '0;
      clr_q      <= '0;
      sram_wr_en <= '0;
      sram_rd_en <= '0;
      sram_addr  <= '0;
      sram_wdata <= '0;
      res_valid  <= 1'b0;
      clear_done <= 1'b0;
      cfg_err    <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_q     <= wait_d;
      clr_q      <= clr_d;
      sram_wr_en <= wr_d;
      sram_rd_en <= rd_d;
      sram_addr  <= addr_d;
      sram_wdata <= wdata_d;
      res_valid  <= |sram_rd_en;
      clear_done <= done_d;
      cfg_err    <= err_d;
    end
  end

endmodule

// File: tb/tb_bv_lookup_config_ctrl.sv
// Testbench for bv_lookup_config_ctrl: directed scenarios plus random
// traffic checked every cycle against a behavioural model.
module tb_bv_lookup_config_ctrl;

  localparam int N = 4, AW = 6, ST = 4, MW = 2, RW = 64;
  localparam int MAXW = 8, DEPTH = 64;

  logic clk = 1'b0;
  logic rst_n;
  logic lk_valid, lk_ready;
  logic [ST*N-1:0] lk_din;
  logic [MW-1:0] lk_mode;
  logic cfg_valid, cfg_ready;
  logic [7:0] cfg_sel;
  logic [AW-1:0] cfg_addr;
  logic [RW-1:0] cfg_data;
  logic clear_start;
  logic [N-1:0] sram_wr_en, sram_rd_en;
  logic [AW*N-1:0] sram_addr;
  logic [RW*N-1:0] sram_wdata;
  logic res_valid, busy, clear_done, cfg_err;

  always #5 clk = ~clk;

  bv_lookup_config_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .lk_valid(lk_valid), .lk_ready(lk_ready),
    .lk_din(lk_din), .lk_mode(lk_mode),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_sel(cfg_sel), .cfg_addr(cfg_addr),
    .cfg_data(cfg_data), .clear_start(clear_start),
    .sram_wr_en(sram_wr_en), .sram_rd_en(sram_rd_en),
    .sram_addr(sram_addr), .sram_wdata(sram_wdata),
    .res_valid(res_valid), .busy(busy),
    .clear_done(clear_done), .cfg_err(cfg_err)
  );

  int checks = 0;
  int errors = 0;

  // Model state
  bit m_clr;
  int m_k, m_wait;
  bit m_err, e_res, e_done;
  logic [N-1:0] e_wr, e_rd;
  logic [AW*N-1:0] e_addr;
  logic [RW*N-1:0] e_wdata;

  task automatic chk(input string tag,
                     input logic [RW*N-1:0] obs,
                     input logic [RW*N-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_clr = 0; m_k = 0; m_wait = 0; m_err = 0;
    e_res = 0; e_done = 0;
    e_wr = '0; e_rd = '0; e_addr = '0; e_wdata = '0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_lkrdy"}, lk_ready, 0);
    chk({tag, "_cfgrdy"}, cfg_ready, 0);
    chk({tag, "_wr"}, sram_wr_en, 0);
    chk({tag, "_rd"}, sram_rd_en, 0);
    chk({tag, "_addr"}, sram_addr, 0);
    chk({tag, "_wdata"}, sram_wdata, 0);
    chk({tag, "_res"}, res_valid, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, clear_done, 0);
    chk({tag, "_err"}, cfg_err, 0);
  endtask

  // Called in the low phase with inputs applied; checks the cycle,
  // advances the model across the next rising edge, returns at negedge.
  task automatic cyc();
    bit idle, elr, ecr, lhs, chs;
    #1;
    idle = !m_clr;
    elr = idle && !clear_start && !(cfg_valid && m_wait == MAXW);
    ecr = idle && !clear_start && (!lk_valid || m_wait == MAXW);
    chk("lk_ready", lk_ready, elr);
    chk("cfg_ready", cfg_ready, ecr);
    chk("wr_en", sram_wr_en, e_wr);
    chk("rd_en", sram_rd_en, e_rd);
    chk("addr", sram_addr, e_addr);
    chk("wdata", sram_wdata, e_wdata);
    chk("res_valid", res_valid, e_res);
    chk("busy", busy, m_clr);
    chk("clear_done", clear_done, e_done);
    chk("cfg_err", cfg_err, m_err);
    lhs = lk_valid && elr;
    chs = cfg_valid && ecr;
    e_res = (e_rd != 0);
    e_rd = lhs ? '1 : '0;
    e_wr = '0;
    e_done = 0;
    if (idle && clear_start) begin
      m_clr = 1; m_k = 0; m_err = 0;
    end else if (m_clr) begin
      if (m_k < DEPTH) begin
        e_wr = '1;
        e_wdata = '0;
        for (int i = 0; i < N; i++) e_addr[i*AW +: AW] = AW'(m_k);
        m_k++;
      end else begin
        m_clr = 0;
        e_done = 1;
      end
    end else if (chs) begin
      if (cfg_sel < N) begin
        e_wr[cfg_sel] = 1'b1;
        e_addr[cfg_sel*AW +: AW] = cfg_addr;
        e_wdata[cfg_sel*RW +: RW] = cfg_data;
      end else begin
        m_err = 1;
      end
    end else if (lhs) begin
      for (int i = 0; i < N; i++)
        e_addr[i*AW +: AW] = {lk_mode, lk_din[i*ST +: ST]};
    end
    if (!cfg_valid || chs) m_wait = 0;
    else if (idle && m_wait < MAXW) m_wait++;
    @(negedge clk);
  endtask

  initial begin
    int first, lk_low, wcnt, done_c, busy_c, rdy_c;
    rst_n = 0;
    lk_valid = 1; lk_din = '0; lk_mode = '0;
    cfg_valid = 1; cfg_sel = '0; cfg_addr = '0; cfg_data = '0;
    clear_start = 0;
    model_reset();
    #2;
    chk_zero("reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
    cfg_valid = 0;

    // Lookup in the very first cycle after reset
    lk_din = 16'hA5C3; lk_mode = 2'b01;
    cyc();
    lk_valid = 0;
    #1;
    chk("lk_addr", sram_addr, {6'h1A, 6'h15, 6'h1C, 6'h13});
    chk("lk_rd", sram_rd_en, 4'hF);
    cyc();
    #1;
    chk("lk_res", res_valid, 1);
    cyc();

    // Config write
    cfg_valid = 1; cfg_sel = 2; cfg_addr = 6'h2A;
    cfg_data = 64'hDEAD_BEEF;
    cyc();
    cfg_valid = 0;
    #1;
    chk("cfg_wr", sram_wr_en, 4'b0100);
    chk("cfg_addr", sram_addr[2*AW +: AW], 6'h2A);
    chk("cfg_wdata", sram_wdata[2*RW +: RW], 64'hDEAD_BEEF);
    cyc();

    // Starvation bound
    lk_valid = 1; cfg_valid = 1; cfg_sel = 1;
    cfg_addr = 6'h05; cfg_data = 64'h1234;
    first = -1; lk_low = 0;
    for (int c = 0; c < 12; c++) begin
      lk_din = 16'($urandom);
      #1;
      if (cfg_ready && first < 0) first = c;
      if (!lk_ready) lk_low++;
      cyc();
      if (first == c) cfg_valid = 0;
    end
    chk("starve_cfg_cycle", first, 8);
    chk("starve_lk_low", lk_low, 1);
    lk_valid = 0;
    cyc();

    // Bad select
    cfg_valid = 1; cfg_sel = 5;
    cyc();
    cfg_valid = 0;
    #1;
    chk("bad_wr", sram_wr_en, 0);
    chk("bad_err", cfg_err, 1);
    repeat (3) cyc();

    // Clear with both requesters pending
    lk_valid = 1; cfg_valid = 1; cfg_sel = 0;
    wcnt = 0; done_c = -1; busy_c = 0; rdy_c = -1;
    for (int c = 0; c <= 70; c++) begin
      clear_start = (c == 0);
      #1;
      if (sram_wr_en == 4'hF && sram_addr[AW-1:0] == AW'(wcnt))
        wcnt++;
      if (clear_done && done_c < 0) done_c = c;
      if (busy) busy_c++;
      if ((lk_ready || cfg_ready) && rdy_c < 0) rdy_c = c;
      cyc();
    end
    chk("clr_writes", wcnt, 64);
    chk("clr_done_cycle", done_c, 66);
    chk("clr_busy_cycles", busy_c, 65);
    chk("clr_first_ready", rdy_c, 66);
    chk("clr_err_cleared", cfg_err, 0);
    lk_valid = 0; cfg_valid = 0; clear_start = 0;
    cyc();

    // Random traffic
    for (int c = 0; c < 400; c++) begin
      lk_valid = 1'($urandom);
      lk_din = 16'($urandom);
      lk_mode = 2'($urandom);
      cfg_valid = ($urandom_range(0, 2) == 0);
      cfg_sel = 8'($urandom_range(0, 5));
      cfg_addr = 6'($urandom);
      cfg_data = {$urandom, $urandom};
      clear_start = ($urandom_range(0, 149) == 0);
      cyc();
    end
    lk_valid = 0; cfg_valid = 0; clear_start = 0;
    repeat (70) cyc();

    // Reset in the middle of a sweep
    clear_start = 1;
    cyc();
    clear_start = 0;
    repeat (21) cyc();
    #1;
    chk("mid_clr_addr", sram_addr[AW-1:0], 20);
    chk("mid_clr_wr", sram_wr_en, 4'hF);
    rst_n = 0;
    #1;
    chk_zero("mid_rst");
    model_reset();
    @(negedge clk);
    rst_n = 1;
    lk_valid = 1;
    done_c = 0;
    for (int c = 0; c < 70; c++) begin
      lk_din = 16'($urandom);
      #1;
      if (clear_done) done_c++;
      cyc();
    end
    chk("post_rst_no_done", done_c, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
